// File: rtl/audio_ram_sequencer.sv
// audio_ram_sequencer: sole master of the DDR2 RAM wrapper. It turns per-sample strobes into
// single-byte writes (record), reads (play) or a zero-fill of the recorded region (delete).
module audio_ram_sequencer #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 8,
  parameter bit LOOP_PLAY  = 1'b0,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              sample_stb,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [ADDR_W-1:0] max_ram_address,
  input  logic              ram_rdy,
  input  logic              ram_rd_data_pres,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  output logic              ram_read_request,
  output logic              ram_read_ack,
  output logic [DATA_W-1:0] play_out,
  output logic              play_valid,
  output logic [ADDR_W-1:0] rec_length,
  output logic              busy,
  output logic              full,
  output logic              overrun,
  output logic              rd_err
);

  localparam logic [1:0] M_PLAY = 2'd0;
  localparam logic [1:0] M_REC  = 2'd1;
  localparam logic [1:0] M_DEL  = 2'd2;
  localparam logic [1:0] M_IDLE = 2'd3;
  // The wait counter only has to hold RD_TIMEOUT-1 before the abort fires.
  localparam int TO_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_RD_ACK, S_CLR
  } state_t;

  state_t            r_state, w_state_next;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, r_clr_ptr, r_rec_length, r_address;
  logic [DATA_W-1:0] r_sample, r_data_in, r_play_out;
  logic              r_pending, r_play_done, r_play_valid, r_full, r_overrun, r_rd_err;
  logic [TO_W-1:0]   r_to_cnt;

  logic w_mode_chg, w_start_wr, w_start_rd, w_start_clr, w_discard;
  logic w_rd_hit, w_rd_timeout, w_rd_last, w_clr_done;

  assign w_rd_last = (r_rd_ptr == r_rec_length - ADDR_W'(1));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_mode_chg   = 1'b0;
    w_start_wr   = 1'b0;
    w_start_rd   = 1'b0;
    w_start_clr  = 1'b0;
    w_discard    = 1'b0;
    w_rd_hit     = 1'b0;
    w_rd_timeout = 1'b0;
    w_clr_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mode != r_mode) begin
          w_mode_chg = 1'b1;
          if (mode == M_DEL) w_state_next = S_CLR;
        end else if (r_pending) begin
          case (r_mode)
            M_REC: begin
              if (r_full) begin
                w_discard = 1'b1;
              end else if (ram_rdy) begin
                w_start_wr   = 1'b1;
                w_state_next = S_WR;
              end
            end
            M_PLAY: begin
              if (r_rec_length == '0 || r_play_done) begin
                w_discard = 1'b1;
              end else if (ram_rdy) begin
                w_start_rd   = 1'b1;
                w_state_next = S_RD_REQ;
              end
            end
            default: w_discard = 1'b1;
          endcase
        end
      end
      S_WR:     w_state_next = (r_mode == M_DEL) ? S_CLR : S_IDLE;
      S_RD_REQ: w_state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (ram_rd_data_pres) begin
          w_rd_hit     = 1'b1;
          w_state_next = S_RD_ACK;
        end else if (r_to_cnt == TO_W'(RD_TIMEOUT - 1)) begin
          w_rd_timeout = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_RD_ACK: w_state_next = S_IDLE;
      S_CLR: begin
        if (r_clr_ptr == r_rec_length) begin
          w_clr_done   = 1'b1;
          w_state_next = S_IDLE;
        end else if (ram_rdy) begin
          w_start_clr  = 1'b1;
          w_state_next = S_WR;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_mode       <= M_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_clr_ptr    <= '0;
      r_rec_length <= '0;
      r_address    <= '0;
      r_sample     <= '0;
      r_data_in    <= '0;
      r_play_out   <= '0;
      r_pending    <= 1'b0;
      r_play_done  <= 1'b0;
      r_play_valid <= 1'b0;
      r_full       <= 1'b0;
      r_overrun    <= 1'b0;
      r_rd_err     <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      r_play_valid <= 1'b0;

      // A strobe landing while a sample is still pending is dropped; the first one wins.
      if (w_mode_chg || w_start_wr || w_start_rd || w_discard) r_pending <= 1'b0;
      if (sample_stb && !w_mode_chg) begin
        if (r_pending) begin
          r_overrun <= 1'b1;
        end else begin
          r_pending <= 1'b1;
          r_sample  <= sample_in;
        end
      end

      if (w_mode_chg) begin
        r_mode    <= mode;
        r_overrun <= 1'b0;
        r_rd_err  <= 1'b0;
        case (mode)
          M_REC: begin
            r_wr_ptr     <= '0;
            r_rec_length <= '0;
            r_full       <= 1'b0;
          end
          M_PLAY: begin
            r_rd_ptr    <= '0;
            r_play_done <= 1'b0;
          end
          M_DEL:   r_clr_ptr <= '0;
          default: ;
        endcase
      end

      if (w_start_wr) begin
        r_address <= r_wr_ptr;
        r_data_in <= r_sample;
      end
      if (w_start_clr) begin
        r_address <= r_clr_ptr;
        r_data_in <= '0;
      end

      if (r_state == S_WR) begin
        if (r_mode == M_DEL) begin
          r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
        end else begin
          r_rec_length <= r_wr_ptr + ADDR_W'(1);
          if (r_wr_ptr == max_ram_address) r_full   <= 1'b1;
          else                             r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
      end
      if (w_clr_done) r_rec_length <= '0;

      if (w_start_rd) begin
        r_address <= r_rd_ptr;
        r_to_cnt  <= '0;
      end
      if (r_state == S_RD_WAIT && !w_rd_hit && !w_rd_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_rd_hit) begin
        r_play_out   <= ram_data_out;
        r_play_valid <= 1'b1;
      end
      if (w_rd_timeout) r_rd_err <= 1'b1;
      // A timed-out read still advances, so playback skips the lost byte.
      if (w_rd_hit || w_rd_timeout) begin
        if (w_rd_last) begin
          r_rd_ptr <= '0;
          if (!LOOP_PLAY) r_play_done <= 1'b1;
        end else begin
          r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        end
      end
    end
  end

  assign ram_write_enable = (r_state == S_WR);
  assign ram_read_request = (r_state == S_RD_REQ);
  assign ram_read_ack     = (r_state == S_RD_ACK);
  assign busy             = (r_state != S_IDLE);
  assign ram_address      = r_address;
  assign ram_data_in      = r_data_in;
  assign play_out         = r_play_out;
  assign play_valid       = r_play_valid;
  assign rec_length       = r_rec_length;
  assign full             = r_full;
  assign overrun          = r_overrun;
  assign rd_err           = r_rd_err;

endmodule

// File: doc/audio_ram_sequencer.md
Name: audio_ram_sequencer

Overview:
- Sequences the DDR2 RAM wrapper (byte address/data, write_enable, read_request/read_ack, rdy, rd_data_pres) for the audio recorder.
- Converts a per-sample strobe into single-byte RAM transactions:
  - RECORD: sequential writes.
  - PLAY: sequential reads with captured output.
  - DELETE: zero-fill of the recorded region.
- Tracks the recorded length. Sits between the PicoBlaze mode register / audio sampler and the RAM wrapper, and is the wrapper's sole master.

Parameters:
ADDR_W, 26, RAM byte address width
DATA_W, 8, sample width
LOOP_PLAY, 0, 1 = playback wraps to address 0 at end of recording; 0 = stop
RD_TIMEOUT, 1023, CLK cycles to wait for rd_data_pres before aborting a read

Ports:
CLK  in  1  system clock (wrapper clkout domain)
reset  in  1  asynchronous, active-low reset
mode  in  2  0=PLAY, 1=RECORD, 2=DELETE, 3=IDLE
sample_stb  in  1  one-cycle sample tick (record: write sample_in; play: fetch next)
sample_in  in  DATA_W  sample to record
max_ram_address  in  ADDR_W  highest usable address, from the wrapper
ram_rdy  in  1  wrapper ready
ram_rd_data_pres  in  1  read data valid
ram_data_out  in  DATA_W  read data from wrapper
ram_address  out  ADDR_W  transaction address
ram_data_in  out  DATA_W  write data
ram_write_enable  out  1  one-cycle write pulse
ram_read_request  out  1  one-cycle read pulse
ram_read_ack  out  1  one-cycle read acknowledge
play_out  out  DATA_W  last sample read
play_valid  out  1  one-cycle pulse when play_out updates
rec_length  out  ADDR_W  number of valid recorded bytes
busy  out  1  high whenever state != S_IDLE
full  out  1  sticky: recording reached max_ram_address
overrun  out  1  sticky: sample_stb arrived while a sample was still pending
rd_err  out  1  sticky: read timed out

Behaviour:
- Reset (reset=0, asynchronous): all outputs and internal registers are 0; state is S_IDLE; the mode register holds IDLE.
- States:
  - S_IDLE
  - S_WR: ram_write_enable=1 for exactly one cycle
  - S_RD_REQ: ram_read_request=1 for one cycle
  - S_RD_WAIT
  - S_RD_ACK: ram_read_ack=1 for one cycle
  - S_CLR: zero-fill write loop
- Mode is sampled only in S_IDLE. A change registered there has these entry actions:
  - RECORD: wr_ptr=0, rec_length=0, full=0.
  - PLAY: rd_ptr=0, play_done=0.
  - DELETE: clr_ptr=0, go to S_CLR.
  - Any change clears overrun and rd_err.
- Pending sample:
  - sample_stb sets a pending flag and latches sample_in.
  - A strobe while the flag is already set is dropped (first sample kept) and sets overrun.
  - Pending is cleared when its transaction starts, and on any mode change.
- No transaction starts unless ram_rdy=1. A transaction already in flight completes regardless of ram_rdy.
- RECORD:
  - Start condition: S_IDLE, pending, !full, ram_rdy.
  - Action: ram_address=wr_ptr, ram_data_in=sample, go to S_WR.
  - Next cycle: back to S_IDLE, rec_length=wr_ptr+1.
  - If wr_ptr==max_ram_address, set full; otherwise wr_ptr+1.
  - While full, pending samples are discarded without a RAM access.
- PLAY:
  - Start condition: S_IDLE, pending, rec_length!=0, !play_done, ram_rdy.
  - Sequence: ram_address=rd_ptr → S_RD_REQ → S_RD_WAIT.
  - In S_RD_WAIT when ram_rd_data_pres=1: play_out=ram_data_out, play_valid pulses in the same cycle as the capture register update, go to S_RD_ACK, then S_IDLE.
  - End of recording (rd_ptr==rec_length-1 after a read): rd_ptr=0; play_done is set if LOOP_PLAY=0.
  - Otherwise rd_ptr+1.
  - Read latency is unbounded up to RD_TIMEOUT. On reaching RD_TIMEOUT cycles in S_RD_WAIT: set rd_err, skip S_RD_ACK, return to S_IDLE; play_out is unchanged, no play_valid, rd_ptr is still advanced.
- DELETE (S_CLR):
  - For each clr_ptr < rec_length, when ram_rdy: write 0 at clr_ptr with a one-cycle ram_write_enable, then clr_ptr+1.
  - When clr_ptr==rec_length (immediately if already 0): rec_length=0, return to S_IDLE.
  - Mode changes during S_CLR are ignored until it finishes.
  - With mode still DELETE, no further action occurs.
- IDLE mode: pending samples are discarded; no RAM traffic.
- ram_write_enable, ram_read_request and ram_read_ack are never high simultaneously and are never high two consecutive cycles.
- Reset asserted mid-transaction aborts it immediately; all strobes drop to 0 asynchronously.

Test Plan:
- Record 3 samples: mode=1, sample_in 8'hA1/8'hB2/8'hC3 with strobes 20 cycles apart, ram_rdy=1 → write pulses at addresses 0/1/2 with those data; rec_length=3.
- Play with loop: after the above, mode=0, LOOP_PLAY=1, 4 strobes, model returns rd_data_pres 5 cycles after request → play_out A1, B2, C3, A1; each play_valid followed by a one-cycle read_ack; LOOP_PLAY=0 variant yields exactly 3 play_valid pulses.
- Full and overrun: max_ram_address=2, record 4 samples → writes at 0..2 only, full=1, rec_length=3; two strobes 1 cycle apart while ram_rdy=0 → overrun=1, only the first sample written once rdy rises.
- Delete: rec_length=3, mode=2, ram_rdy toggling → three zero writes at 0, 1, 2; busy high throughout; rec_length=0; switching to mode=0 mid-clear takes effect only after the last write.
- Read timeout: model never asserts rd_data_pres, RD_TIMEOUT=15 → rd_err=1 after 15 wait cycles; no read_ack; no play_valid; next strobe reads address 1.
- Async reset during S_RD_WAIT: reset=0 between clock edges → all outputs 0 immediately, including mid-cycle; after release, rec_length=0 and state is S_IDLE.
